// File: rtl/ddr3_addr_lane_tx_ctrl.sv
// DDR3 address/command lane driver feeding a PolarFire IOD: 4:1 TX/OE data registers
// plus a MOVE/LOAD sequencer for the IOD dynamic delay line. Optional macro: DDR3_ADDR_HOLD_EN.
module ddr3_addr_lane_tx_ctrl #(
  parameter int   TAP_CNT_W  = 8,
  parameter int   MOVE_GAP   = 4,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                 FAB_CLK,
  input  logic                 ARST,
  input  logic [3:0]           ADDR_PHASE,
  input  logic                 ADDR_VALID,
  input  logic                 DRIVE_EN,
  output logic [3:0]           TX_DATA_0,
  output logic [3:0]           OE_DATA_0,
  input  logic                 ADJ_REQ,
  input  logic                 ADJ_DIR,
  input  logic [TAP_CNT_W-1:0] ADJ_TAPS,
  input  logic                 ADJ_LOAD,
  input  logic                 ADJ_ERR_CLR,
  output logic                 ADJ_BUSY,
  output logic                 ADJ_DONE,
  output logic                 ADJ_ERR,
  output logic [TAP_CNT_W-1:0] TAP_MOVED,
  output logic                 DELAY_LINE_MOVE_0,
  output logic                 DELAY_LINE_DIRECTION_0,
  output logic                 DELAY_LINE_LOAD_0,
  input  logic                 DELAY_LINE_OUT_OF_RANGE_0
);

  localparam int GAP_W = (MOVE_GAP > 1) ? $clog2(MOVE_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(MOVE_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_MOVE, S_LOAD, S_GAP, S_DONE
  } state_t;

  state_t               state, state_n;
  logic [3:0]           tx_q, oe_q;
  logic                 dir_q, load_op, err_q;
  logic [TAP_CNT_W-1:0] rem, tap_q;
  logic [GAP_W-1:0]     gap_cnt;
  logic                 gap_end, oor_hit, start_req, start_load;

  // Data path: one register stage in front of the IOD 4:1 serialiser
  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) begin
      tx_q <= {4{IDLE_LEVEL}};
      oe_q <= 4'b0000;
    end else begin
      oe_q <= {4{DRIVE_EN}};
      if (ADDR_VALID)
        tx_q <= ADDR_PHASE;
`ifdef DDR3_ADDR_HOLD_EN
      else
        tx_q <= tx_q;
`else
      else
        tx_q <= {4{IDLE_LEVEL}};
`endif
    end
  end

  assign start_load = (state == S_IDLE) && ADJ_LOAD;
  assign start_req  = (state == S_IDLE) && !ADJ_LOAD && ADJ_REQ;
  assign gap_end    = (gap_cnt == GAP_LAST);
  assign oor_hit    = (state == S_GAP) && DELAY_LINE_OUT_OF_RANGE_0;

  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) state <= S_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (ADJ_LOAD)                       state_n = S_LOAD;
        else if (ADJ_REQ && ADJ_TAPS != '0) state_n = S_SETUP;
        else if (ADJ_REQ)                   state_n = S_DONE;
      end
      S_SETUP: state_n = S_MOVE;
      S_MOVE:  state_n = S_GAP;
      S_LOAD:  state_n = S_GAP;
      S_GAP: begin
        // Out-of-range aborts immediately; leftover taps are dropped
        if (DELAY_LINE_OUT_OF_RANGE_0)        state_n = S_DONE;
        else if (gap_end && (rem == '0 || load_op)) state_n = S_DONE;
        else if (gap_end)                     state_n = S_MOVE;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) begin
      dir_q   <= 1'b0;
      load_op <= 1'b0;
      rem     <= '0;
      tap_q   <= '0;
      gap_cnt <= '0;
    end else begin
      if (start_req) begin
        dir_q   <= ADJ_DIR;
        rem     <= ADJ_TAPS;
        tap_q   <= '0;
        load_op <= 1'b0;
      end else if (start_load) begin
        load_op <= 1'b1;
      end
      if (state == S_MOVE) begin
        rem <= rem - 1'b1;
        if (tap_q != '1) tap_q <= tap_q + 1'b1;
      end
      if (state == S_GAP && !gap_end) gap_cnt <= gap_cnt + 1'b1;
      else                            gap_cnt <= '0;
    end
  end

  // Sticky error: a new hit wins over a simultaneous clear
  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST)             err_q <= 1'b0;
    else if (oor_hit)     err_q <= 1'b1;
    else if (ADJ_ERR_CLR) err_q <= 1'b0;
  end

  assign TX_DATA_0              = tx_q;
  assign OE_DATA_0              = oe_q;
  assign ADJ_BUSY               = (state != S_IDLE);
  assign ADJ_DONE               = (state == S_DONE);
  assign ADJ_ERR                = err_q;
  assign TAP_MOVED              = tap_q;
  assign DELAY_LINE_MOVE_0      = (state == S_MOVE);
  assign DELAY_LINE_LOAD_0      = (state == S_LOAD);
  assign DELAY_LINE_DIRECTION_0 = dir_q;

endmodule

// File: tb/tb_ddr3_addr_lane_tx_ctrl.sv
// Scoreboard bench for ddr3_addr_lane_tx_ctrl: stimulus pushes expectations, monitors pop on output events.
module tb_ddr3_addr_lane_tx_ctrl;
  localparam int TW  = 8;
  localparam int GAP = 4;

  logic          FAB_CLK = 1'b0, ARST = 1'b1;
  logic [3:0]    ADDR_PHASE = '0;
  logic          ADDR_VALID = 1'b0, DRIVE_EN = 1'b0;
  logic [3:0]    TX_DATA_0, OE_DATA_0;
  logic          ADJ_REQ = 1'b0, ADJ_DIR = 1'b0, ADJ_LOAD = 1'b0, ADJ_ERR_CLR = 1'b0;
  logic [TW-1:0] ADJ_TAPS = '0;
  logic          ADJ_BUSY, ADJ_DONE, ADJ_ERR;
  logic [TW-1:0] TAP_MOVED;
  logic          DELAY_LINE_MOVE_0, DELAY_LINE_DIRECTION_0, DELAY_LINE_LOAD_0;
  logic          DELAY_LINE_OUT_OF_RANGE_0 = 1'b0;

  ddr3_addr_lane_tx_ctrl #(.TAP_CNT_W(TW), .MOVE_GAP(GAP), .IDLE_LEVEL(1'b0)) dut (
    .FAB_CLK(FAB_CLK), .ARST(ARST), .ADDR_PHASE(ADDR_PHASE), .ADDR_VALID(ADDR_VALID),
    .DRIVE_EN(DRIVE_EN), .TX_DATA_0(TX_DATA_0), .OE_DATA_0(OE_DATA_0),
    .ADJ_REQ(ADJ_REQ), .ADJ_DIR(ADJ_DIR), .ADJ_TAPS(ADJ_TAPS), .ADJ_LOAD(ADJ_LOAD),
    .ADJ_ERR_CLR(ADJ_ERR_CLR), .ADJ_BUSY(ADJ_BUSY), .ADJ_DONE(ADJ_DONE), .ADJ_ERR(ADJ_ERR),
    .TAP_MOVED(TAP_MOVED), .DELAY_LINE_MOVE_0(DELAY_LINE_MOVE_0),
    .DELAY_LINE_DIRECTION_0(DELAY_LINE_DIRECTION_0), .DELAY_LINE_LOAD_0(DELAY_LINE_LOAD_0),
    .DELAY_LINE_OUT_OF_RANGE_0(DELAY_LINE_OUT_OF_RANGE_0)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  typedef struct {
    int moves; int loads; int tap; bit err; bit dir;
  } adj_exp_t;

  adj_exp_t   aq[$];
  logic [7:0] dq[$];
  int total = 0, bad = 0;

`ifdef DDR3_ADDR_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitors sample 1 time unit after the active edge
  int  cyc = 0, mv_cnt = 0, ld_cnt = 0, last_mv = 0;
  bit  have_last = 0, mv_dir = 0;
  always @(posedge FAB_CLK) begin
    #1;
    cyc++;
    if (dq.size() != 0) begin
      logic [7:0] e;
      e = dq.pop_front();
      chk("tx_data", int'(TX_DATA_0), int'(e[7:4]));
      chk("oe_data", int'(OE_DATA_0), int'(e[3:0]));
    end
    if (ARST) begin
      mv_cnt = 0; ld_cnt = 0; have_last = 0;
    end else begin
      if (DELAY_LINE_MOVE_0) begin
        if (have_last) chk("move_spacing", cyc - last_mv, GAP + 1);
        last_mv = cyc; have_last = 1; mv_cnt++; mv_dir = DELAY_LINE_DIRECTION_0;
      end
      if (DELAY_LINE_LOAD_0) ld_cnt++;
      if (ADJ_DONE) begin
        if (aq.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          adj_exp_t e;
          e = aq.pop_front();
          chk("move_count", mv_cnt, e.moves);
          chk("load_count", ld_cnt, e.loads);
          chk("tap_moved", int'(TAP_MOVED), e.tap);
          chk("adj_err", int'(ADJ_ERR), int'(e.err));
          if (e.moves > 0) chk("move_dir", int'(mv_dir), int'(e.dir));
        end
        mv_cnt = 0; ld_cnt = 0; have_last = 0;
      end
    end
  end

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge FAB_CLK); n++;
    end while (ADJ_BUSY && n < 300);
    if (ADJ_BUSY) chk({name, "_timeout"}, 1, 0);
  endtask

  task automatic pulse_req(input bit dir, input int taps, input bit load);
    @(negedge FAB_CLK);
    ADJ_REQ = 1'b1; ADJ_DIR = dir; ADJ_TAPS = TW'(taps); ADJ_LOAD = load;
  endtask

  task automatic drop_req();
    @(negedge FAB_CLK);
    ADJ_REQ = 1'b0; ADJ_LOAD = 1'b0;
  endtask

  initial begin
    int n;
    #2;
    chk("rst_tx", int'(TX_DATA_0), 0);
    chk("rst_oe", int'(OE_DATA_0), 0);
    chk("rst_busy_done", int'({ADJ_BUSY, ADJ_DONE, ADJ_ERR}), 0);
    chk("rst_dl", int'({DELAY_LINE_MOVE_0, DELAY_LINE_LOAD_0, DELAY_LINE_DIRECTION_0}), 0);
    chk("rst_tap", int'(TAP_MOVED), 0);
    @(negedge FAB_CLK); @(negedge FAB_CLK);
    ARST = 1'b0;

    // Data path
    @(negedge FAB_CLK);
    ADDR_VALID = 1; ADDR_PHASE = 4'b1010; DRIVE_EN = 1; dq.push_back(8'b1010_1111);
    @(negedge FAB_CLK);
    ADDR_VALID = 0; ADDR_PHASE = 4'b0101; DRIVE_EN = 0;
    dq.push_back(HOLD ? 8'b1010_0000 : 8'b0000_0000);
    @(negedge FAB_CLK);
    ADDR_VALID = 1; ADDR_PHASE = 4'b0011; DRIVE_EN = 1; dq.push_back(8'b0011_1111);
    @(negedge FAB_CLK);
    ADDR_VALID = 0; ADDR_PHASE = 4'b1111; dq.push_back(HOLD ? 8'b0011_1111 : 8'b0000_1111);
    @(negedge FAB_CLK);

    // Three-tap step, direction up
    pulse_req(1, 3, 0); aq.push_back('{3, 0, 3, 0, 1});
    drop_req();
    chk("setup_busy", int'(ADJ_BUSY), 1);
    chk("setup_dir", int'(DELAY_LINE_DIRECTION_0), 1);
    chk("setup_no_move", int'(DELAY_LINE_MOVE_0), 0);
    wait_idle("step3");

    // Out of range after the second move
    pulse_req(0, 10, 0); aq.push_back('{2, 0, 2, 1, 0});
    drop_req();
    n = 0;
    while (n < 2 && ADJ_BUSY) begin
      if (DELAY_LINE_MOVE_0) n++;
      if (n < 2) @(negedge FAB_CLK);
    end
    chk("oor_reached_move2", n, 2);
    DELAY_LINE_OUT_OF_RANGE_0 = 1;
    @(negedge FAB_CLK); @(negedge FAB_CLK);
    DELAY_LINE_OUT_OF_RANGE_0 = 0;
    wait_idle("oor");
    chk("err_sticky", int'(ADJ_ERR), 1);
    @(negedge FAB_CLK); ADJ_ERR_CLR = 1;
    @(negedge FAB_CLK); ADJ_ERR_CLR = 0;
    chk("err_cleared", int'(ADJ_ERR), 0);

    // LOAD beats REQ; TAP_MOVED keeps the previous value
    pulse_req(1, 5, 1); aq.push_back('{0, 1, 2, 0, 0});
    drop_req();
    wait_idle("load");

    // Zero taps: straight to DONE
    pulse_req(0, 0, 0); aq.push_back('{0, 0, 0, 0, 0});
    @(posedge FAB_CLK); #1;
    chk("zero_done_pulse", int'(ADJ_DONE), 1);
    drop_req();
    wait_idle("zero");

    // Request while busy is dropped
    pulse_req(1, 3, 0); aq.push_back('{3, 0, 3, 0, 1});
    drop_req();
    repeat (3) @(negedge FAB_CLK);
    ADJ_REQ = 1; ADJ_TAPS = 8'd5; ADJ_DIR = 0;
    @(negedge FAB_CLK); ADJ_REQ = 0;
    wait_idle("busy");

    // Reset mid-GAP
    pulse_req(1, 5, 0);
    drop_req();
    n = 0;
    while (!DELAY_LINE_MOVE_0 && n < 50) begin @(negedge FAB_CLK); n++; end
    @(negedge FAB_CLK); @(negedge FAB_CLK);
    ARST = 1; #1;
    chk("arst_move", int'(DELAY_LINE_MOVE_0), 0);
    chk("arst_load", int'(DELAY_LINE_LOAD_0), 0);
    chk("arst_busy", int'(ADJ_BUSY), 0);
    chk("arst_tap", int'(TAP_MOVED), 0);
    @(negedge FAB_CLK); ARST = 0;
    repeat (3) @(negedge FAB_CLK);
    chk("post_rst_idle", int'({ADJ_BUSY, DELAY_LINE_MOVE_0}), 0);
    pulse_req(0, 1, 0); aq.push_back('{1, 0, 1, 0, 0});
    drop_req();
    wait_idle("post_rst");

    repeat (3) @(negedge FAB_CLK);
    chk("adj_sb_empty", aq.size(), 0);
    chk("data_sb_empty", dq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
